// File: rtl/lu_arbiter_seq.sv
// Two-requester round-robin front end for a shared 1-bit logic unit.
// Each granted job is streamed LSB first through the unit and the three z outputs are collected into words.
module lu_arbiter_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             lu_a,
  output logic             lu_b,
  input  logic [2:0]       lu_z,
  output logic             res_valid,
  output logic             res_id,
  output logic [WIDTH-1:0] res_z0,
  output logic [WIDTH-1:0] res_z1,
  output logic [WIDTH-1:0] res_z2,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             last_id;
  logic             job_id;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             grant_any;
  logic             grant_id;
  logic             xfer;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_id;
    end else begin
      grant_id = req1_valid;
    end
  end

  assign xfer       = (state == IDLE) && grant_any;
  assign req0_ready = xfer && !grant_id;
  assign req1_ready = xfer && grant_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      last_id <= 1'b1;
      job_id  <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            a_reg   <= grant_id ? req1_a : req0_a;
            b_reg   <= grant_id ? req1_b : req0_b;
            job_id  <= grant_id;
            last_id <= grant_id;
            cnt     <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == LAST_BIT) begin
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Result words keep the last completed job until the next job starts shifting in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_z0 <= '0;
      res_z1 <= '0;
      res_z2 <= '0;
      res_id <= 1'b0;
    end else if (state == SHIFT) begin
      res_z0[cnt] <= lu_z[0];
      res_z1[cnt] <= lu_z[1];
      res_z2[cnt] <= lu_z[2];
      if (cnt == LAST_BIT) begin
        res_id <= job_id;
      end
    end
  end

  assign lu_a      = (state == SHIFT) ? a_reg[cnt] : 1'b0;
  assign lu_b      = (state == SHIFT) ? b_reg[cnt] : 1'b0;
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_lu_arbiter_seq.sv
// Directed bench for lu_arbiter_seq with a behavioural logic unit z = {a^b, a|b, a&b}.
module tb_lu_arbiter_seq;

  typedef struct {
    string      name;
    logic       k;
    logic [7:0] a;
    logic [7:0] b;
    logic       corrupt;
    logic       exp_id;
    logic [7:0] z0;
    logic [7:0] z1;
    logic [7:0] z2;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       lu_a, lu_b;
  logic [2:0] lu_z;
  logic       res_valid, res_id;
  logic [7:0] res_z0, res_z1, res_z2;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int both_ready_cnt = 0;

  int         obs_lat;
  logic [7:0] obs_la, obs_lb, obs_z0, obs_z1, obs_z2;
  logic       obs_id, obs_pulse_after, obs_busy_after;
  logic [1:0] obs_done_lu, obs_idle_lu;

  vec_t vecs[7];

  lu_arbiter_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .lu_a(lu_a), .lu_b(lu_b), .lu_z(lu_z),
    .res_valid(res_valid), .res_id(res_id),
    .res_z0(res_z0), .res_z1(res_z1), .res_z2(res_z2),
    .busy(busy)
  );

  assign lu_z = {lu_a ^ lu_b, lu_a | lu_b, lu_a & lu_b};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    #1;
    if (req0_ready && req1_ready) both_ready_cnt++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Called just after the transfer edge; follows the job to its result pulse and one edge beyond.
  task automatic waitResult(input logic corrupt);
    obs_la    = 8'h00;
    obs_lb    = 8'h00;
    obs_la[0] = lu_a;
    obs_lb[0] = lu_b;
    obs_lat   = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (corrupt && n == 1) req0_a = 8'h00;
      if (res_valid) begin
        obs_lat = n;
        break;
      end
      if (n < 8) begin
        obs_la[n[2:0]] = lu_a;
        obs_lb[n[2:0]] = lu_b;
      end
    end
    obs_id      = res_id;
    obs_z0      = res_z0;
    obs_z1      = res_z1;
    obs_z2      = res_z2;
    obs_done_lu = {lu_a, lu_b};
    @(posedge clk); #1;
    obs_pulse_after = res_valid;
    obs_busy_after  = busy;
    obs_idle_lu     = {lu_a, lu_b};
  endtask

  task automatic applyStimulus(input vec_t v);
    logic got;
    @(negedge clk);
    if (!v.k) begin
      req0_valid = 1'b1; req0_a = v.a; req0_b = v.b;
    end else begin
      req1_valid = 1'b1; req1_a = v.a; req1_b = v.b;
    end
    #1;
    got = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (v.k ? req1_ready : req0_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    checkOutput({v.name, "_grant"}, 32'(got), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    waitResult(v.corrupt);
  endtask

  task automatic runVector(input vec_t v);
    applyStimulus(v);
    checkOutput({v.name, "_latency"}, 32'(obs_lat), 32'd8);
    checkOutput({v.name, "_res_id"}, 32'(obs_id), 32'(v.exp_id));
    checkOutput({v.name, "_res_z0"}, 32'(obs_z0), 32'(v.z0));
    checkOutput({v.name, "_res_z1"}, 32'(obs_z1), 32'(v.z1));
    checkOutput({v.name, "_res_z2"}, 32'(obs_z2), 32'(v.z2));
    checkOutput({v.name, "_lu_a_serial"}, 32'(obs_la), 32'(v.a));
    checkOutput({v.name, "_lu_b_serial"}, 32'(obs_lb), 32'(v.b));
    checkOutput({v.name, "_lu_done_zero"}, 32'(obs_done_lu), 32'd0);
    checkOutput({v.name, "_pulse_one_cycle"}, 32'(obs_pulse_after), 32'd0);
    checkOutput({v.name, "_busy_idle"}, 32'(obs_busy_after), 32'd0);
    checkOutput({v.name, "_lu_idle_zero"}, 32'(obs_idle_lu), 32'd0);
  endtask

  initial begin
    time  t0, t1;
    logic got;
    int   pulses;

    vecs[0] = '{"single_req0",  1'b0, 8'hA5, 8'h3C, 1'b0, 1'b0, 8'h24, 8'hBD, 8'h99};
    vecs[1] = '{"single_req1",  1'b1, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 8'hFF, 8'hFF};
    vecs[2] = '{"operand_chg",  1'b0, 8'hA5, 8'h3C, 1'b1, 1'b0, 8'h24, 8'hBD, 8'h99};
    vecs[3] = '{"serial_81",    1'b0, 8'h81, 8'h3C, 1'b0, 1'b0, 8'h00, 8'hBD, 8'hBD};
    vecs[4] = '{"req1_0f_f0",   1'b1, 8'h0F, 8'hF0, 1'b0, 1'b1, 8'h00, 8'hFF, 8'hFF};
    vecs[5] = '{"req0_zero",    1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[6] = '{"req1_5a_3c",   1'b1, 8'h5A, 8'h3C, 1'b0, 1'b1, 8'h18, 8'h7E, 8'h66};

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 8'h00; req0_b = 8'h00; req1_a = 8'h00; req1_b = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_lu_ab", 32'({lu_a, lu_b}), 32'd0);
    checkOutput("rst_res_id", 32'(res_id), 32'd0);
    checkOutput("rst_res_z", 32'({res_z0, res_z1, res_z2}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Tie straight after reset: requester 0 first, requester 1 exactly ten cycles later.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'h00;
    req1_valid = 1'b1; req1_a = 8'h0F; req1_b = 8'hF0;
    #1;
    t0 = $time;
    checkOutput("tie_req0_ready", 32'(req0_ready), 32'd1);
    checkOutput("tie_req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    waitResult(1'b0);
    checkOutput("tie_first_latency", 32'(obs_lat), 32'd8);
    checkOutput("tie_first_id", 32'(obs_id), 32'd0);
    checkOutput("tie_first_z1", 32'(obs_z1), 32'hFF);
    checkOutput("tie_first_z0", 32'(obs_z0), 32'h00);
    @(negedge clk); #1;
    got = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (req1_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    t1 = $time;
    checkOutput("tie_second_grant", 32'(got), 32'd1);
    checkOutput("tie_spacing", 32'(t1 - t0), 32'd100);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    waitResult(1'b0);
    checkOutput("tie_second_id", 32'(obs_id), 32'd1);
    checkOutput("tie_second_z2", 32'(obs_z2), 32'hFF);
    checkOutput("tie_second_z0", 32'(obs_z0), 32'h00);
    checkOutput("tie_second_z1", 32'(obs_z1), 32'hFF);

    for (int i = 0; i < 7; i++) begin
      runVector(vecs[i]);
    end

    // Last table job was requester 1, so continuous contention must alternate starting with 0.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 8'hA5; req0_b = 8'h3C;
    req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h00;
    for (int j = 0; j < 4; j++) begin
      got = 1'b0;
      for (int n = 0; n < 40; n++) begin
        @(posedge clk); #1;
        if (res_valid) begin
          got = 1'b1;
          break;
        end
      end
      checkOutput("fair_pulse_seen", 32'(got), 32'd1);
      checkOutput("fair_res_id", 32'(res_id), 32'(j % 2));
      checkOutput("fair_res_z1", 32'(res_z1), (j % 2 == 1) ? 32'hFF : 32'hBD);
      if (j == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("fair_no_extra_job", 32'(busy), 32'd0);

    // Abort a job three bits in; outputs clear at once and no result ever appears.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'hFF;
    #1;
    checkOutput("abort_grant", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_pre_lu_a", 32'(lu_a), 32'd1);
    checkOutput("abort_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_lu_ab", 32'({lu_a, lu_b}), 32'd0);
    checkOutput("abort_res_valid", 32'(res_valid), 32'd0);
    checkOutput("abort_res_id", 32'(res_id), 32'd0);
    checkOutput("abort_res_z0", 32'(res_z0), 32'd0);
    checkOutput("abort_res_z1", 32'(res_z1), 32'd0);
    checkOutput("abort_res_z2", 32'(res_z2), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (res_valid) pulses++;
    end
    checkOutput("abort_no_pulse", 32'(pulses), 32'd0);
    checkOutput("abort_idle_busy", 32'(busy), 32'd0);
    runVector(vecs[6]);

    checkOutput("ready_exclusive", 32'(both_ready_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lu_arbiter_seq.md
LU_ARBITER_SEQ -- requirements
Module: lu_arbiter_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand bit width; legal range is 2..32.
REQ-002 Port clk SHALL be an input, 1 bit wide, and is the single clock; the block SHALL act on its rising edge only.
REQ-003 Port rst SHALL be an input, 1 bit wide, and is the reset; it SHALL be asynchronous and active-high.
REQ-004 Ports req0_valid and req1_valid SHALL be inputs, 1 bit wide each, and mean "requester k has a job pending".
REQ-005 Ports req0_a, req0_b, req1_a and req1_b SHALL be inputs, WIDTH bits wide each, carrying requester k's operand words.
REQ-006 Ports req0_ready and req1_ready SHALL be outputs, 1 bit wide each; a job transfers on a rising edge where valid and ready are both 1.
REQ-007 Ports lu_a and lu_b SHALL be outputs, 1 bit wide each, and drive the a and b inputs of the shared 2-input logic unit.
REQ-008 Port lu_z SHALL be an input, 3 bits wide, and is the logic unit's combinational z output.
REQ-009 Port res_valid SHALL be an output, 1 bit wide, and is a one-cycle pulse marking a completed job.
REQ-010 Port res_id SHALL be an output, 1 bit wide, giving the requester index of the completed job.
REQ-011 Ports res_z0, res_z1 and res_z2 SHALL be outputs, WIDTH bits wide each; bit i of res_zk holds lu_z[k] sampled for operand bit i.
REQ-012 Port busy SHALL be an output, 1 bit wide, and SHALL be 1 whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE, with exactly one reqk_valid=1, that requester SHALL be granted.
REQ-015 In IDLE, with both valid, the block SHALL grant the requester not served last (round-robin pointer last_id).
REQ-016 reqk_ready SHALL equal (state==IDLE && granted==k), be combinational, and never be 1 for both requesters at once.
REQ-017 On transfer, the block SHALL capture the operands into a_reg/b_reg, record the granted id, set last_id to it, clear bit counter cnt to 0 and go to SHIFT.
REQ-018 In SHIFT, lu_a SHALL equal a_reg[cnt] and lu_b SHALL equal b_reg[cnt] (LSB first); each rising edge SHALL write lu_z[k] into res_zk[cnt] and increment cnt.
REQ-019 When cnt==WIDTH-1 in SHIFT, the next edge SHALL go to DONE with no wrap beyond WIDTH-1.
REQ-020 In DONE, res_valid SHALL be 1 for exactly one cycle with res_id equal to the job's id; the next edge SHALL go to IDLE.
REQ-021 Latency: res_valid SHALL be high in the cycle beginning WIDTH edges after the transfer edge; throughput is one job per WIDTH+2 cycles.
REQ-022 In IDLE and DONE, lu_a and lu_b SHALL be 0.
REQ-023 res_z0..res_z2 and res_id SHALL hold their values until overwritten by the next job; bits of the job in progress update during SHIFT.
REQ-024 Operand changes on req inputs after transfer SHALL have no effect on the job in progress.
REQ-025 A valid deasserted before transfer SHALL cause no grant and no pointer change.

Reset
REQ-026 rst=1 SHALL force immediately: state=IDLE, cnt=0, last_id=1 (so requester 0 wins the first tie), a_reg=b_reg=0, res_z0..2=0, res_id=0, res_valid=0, busy=0, lu_a=lu_b=0.
REQ-027 A reset during SHIFT or DONE SHALL abort the job with no res_valid pulse; the aborted requester SHALL NOT be re-served unless it re-asserts valid.

Verification (bench model lu_z={a^b, a|b, a&b}, WIDTH=8)
REQ-028 Single job: req0 a=8'hA5, b=8'h3C -> res_valid pulse 8 edges after transfer, res_id=0, res_z0=8'h24, res_z1=8'hBD, res_z2=8'h99.
REQ-029 Tie after reset: both valid (req0 a=8'hFF b=8'h00, req1 a=8'h0F b=8'hF0) -> req0 served first (res_z1=8'hFF), then req1 (res_z2=8'hFF, res_z0=8'h00); transfers 10 cycles apart.
REQ-030 Fairness: both valid continuously for 4 jobs -> res_id sequence 0,1,0,1; the two ready signals are never 1 together.
REQ-031 Reset mid-SHIFT: assert rst at cnt=3 -> all outputs 0 at once; no res_valid; busy=0; the next req1 job completes correctly.
REQ-032 Operand change: change req0_a to 8'h00 one cycle after the transfer of 8'hA5 -> results still match 8'hA5.
REQ-033 Serial drive: during SHIFT for a=8'h81, lu_a SHALL read 1,0,0,0,0,0,0,1 over successive cycles; lu_a=lu_b=0 in IDLE and DONE.
